// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - state encoding and data-memory geometry shared with the memory side
package mem_access_ctrl_pkg;

   localparam int MEM_DATA_W = 32;
   localparam int MEM_WORDS  = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2,
      RESP    = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_ctrl_timeout_cnt.sv
// rtl/mem_access_ctrl_timeout_cnt.sv - wait-cycle counter that flags the last permitted wait cycle
module mem_timeout_cnt #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic hit
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Asserted while the count is one short, so the edge that brings it to TIMEOUT aborts the access.
   assign hit = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store initiator for the data-memory handshake
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int DATA_W  = MEM_DATA_W,
   parameter int WORDS   = MEM_WORDS,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              stall,
   output logic              MemRd,
   output logic              MemWr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              MemRdComp,
   input  logic              MemWrComp,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [DATA_W-1:0] ADDR_LIMIT = DATA_W'(WORDS * 4);

   state_t            state_q, state_d;
   logic              cnt_clr, cnt_en, cnt_hit, timeout;
   logic              accept, addr_bad, rd_done;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   assign addr_bad = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);
   assign accept   = (state_q == IDLE) && req_valid;
   assign rd_done  = (state_q == RD_WAIT) && MemRdComp;

   mem_timeout_cnt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clr),
      .enable (cnt_en),
      .hit    (cnt_hit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A matching completion is checked before the timeout so it wins when both land together.
   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cnt_clr = 1'b1;
               if (addr_bad)    state_d = RESP;
               else if (req_we) state_d = WR_WAIT;
               else             state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (MemRdComp) begin
               state_d = RESP;
            end else begin
               cnt_en  = 1'b1;
               timeout = cnt_hit;
               if (cnt_hit) state_d = RESP;
            end
         end
         WR_WAIT: begin
            if (MemWrComp) begin
               state_d = RESP;
            end else begin
               cnt_en  = 1'b1;
               timeout = cnt_hit;
               if (cnt_hit) state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            rdata_q   <= '0;
            err_q     <= addr_bad;
         end
         if (rd_done) rdata_q <= mem_rdata;
         if (timeout) err_q <= 1'b1;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign stall      = (state_q != IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign MemRd      = (state_q == RD_WAIT);
   assign MemWr      = (state_q == WR_WAIT);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed bench with a transaction-level model and a per-cycle compare process
module tb_mem_access_ctrl;

   localparam int TIMEOUT = 15;
   localparam int WORDS   = 16;

   logic        clk;
   logic        reset;
   logic        req_valid, req_we, req_ready;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err, stall;
   logic [31:0] resp_rdata;
   logic        MemRd, MemWr, MemRdComp, MemWrComp;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] phys_mem  [WORDS];
   logic [31:0] model_mem [WORDS];

   logic        exp_armed, exp_we, exp_err;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic        o_err;
   logic [31:0] o_rdata;
   int          o_strobes;

   mem_access_ctrl #(
      .DATA_W  (32),
      .WORDS   (WORDS),
      .TIMEOUT (TIMEOUT),
      .CNT_W   (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .stall      (stall),
      .MemRd      (MemRd),
      .MemWr      (MemWr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .MemRdComp  (MemRdComp),
      .MemWrComp  (MemWrComp),
      .mem_rdata  (mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Transaction-level rules: address legality, completion latency versus timeout, memory effect.
   task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input int lat, output logic err, output logic [31:0] rdata,
                               output int strobes);
      if (addr[1:0] != 2'b00 || addr >= 32'(WORDS * 4)) begin
         err = 1'b1; rdata = '0; strobes = 0;
      end else if (lat >= 1 && lat <= TIMEOUT) begin
         err = 1'b0; strobes = lat;
         if (we) begin
            model_mem[addr[5:2]] = wdata;
            rdata = '0;
         end else begin
            rdata = model_mem[addr[5:2]];
         end
      end else begin
         err = 1'b1; rdata = '0; strobes = TIMEOUT;
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         chk1("inv_ready_vs_stall", req_ready, !stall);
         chk1("inv_rd_wr_exclusive", MemRd & MemWr, 1'b0);
         if (resp_valid) begin
            chk1("cmp_resp_expected", exp_armed, 1'b1);
            chk1("cmp_resp_err", resp_err, exp_err);
            chk("cmp_resp_rdata", resp_rdata, exp_rdata);
         end
         if (MemRd) begin
            chk1("cmp_rd_is_load", exp_we, 1'b0);
            chk("cmp_rd_addr", mem_addr, exp_addr);
         end
         if (MemWr) begin
            chk1("cmp_wr_is_store", exp_we, 1'b1);
            chk("cmp_wr_addr", mem_addr, exp_addr);
            chk("cmp_wr_wdata", mem_wdata, exp_wdata);
         end
      end
   end

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int lat, input int hold, input logic wrong_comp, input string tag);
      logic        e;
      logic [31:0] rd;
      int          strobes, n, c;
      logic        got;
      model_access(we, addr, wdata, lat, e, rd, strobes);
      exp_we = we; exp_addr = addr; exp_wdata = wdata; exp_err = e; exp_rdata = rd; exp_armed = 1'b1;
      @(negedge clk);
      chk1({tag, "_ready_before"}, req_ready, 1'b1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0; c = 0; got = 1'b0;
      o_err = 1'bx; o_rdata = 'x;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         MemRdComp = 1'b0; MemWrComp = 1'b0; mem_rdata = 32'hBAD0_0000;
         if (resp_valid) begin
            got = 1'b1; c = i; o_err = resp_err; o_rdata = resp_rdata;
         end else if (MemRd || MemWr) begin
            n++;
            if (MemRd && wrong_comp) MemWrComp = 1'b1;
            if (n == lat) begin
               if (MemRd) begin
                  MemRdComp = 1'b1;
                  mem_rdata = phys_mem[mem_addr[5:2]];
               end else begin
                  MemWrComp = 1'b1;
                  phys_mem[mem_addr[5:2]] = mem_wdata;
               end
            end
         end
      end
      MemRdComp = 1'b0; MemWrComp = 1'b0;
      o_strobes = n;
      chk1({tag, "_resp_seen"}, got, 1'b1);
      chk({tag, "_strobe_cycles"}, n, strobes);
      chk({tag, "_latency"}, c, strobes + 1);
      chk1({tag, "_err"}, o_err, e);
      chk({tag, "_rdata"}, o_rdata, rd);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk1({tag, "_hold_valid"}, resp_valid, 1'b1);
         chk1({tag, "_hold_not_ready"}, req_ready, 1'b0);
         chk({tag, "_hold_rdata"}, resp_rdata, o_rdata);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      exp_armed = 1'b0;
      chk1({tag, "_idle_ready"}, req_ready, 1'b1);
      chk1({tag, "_idle_no_resp"}, resp_valid, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < WORDS; i++) begin
         phys_mem[i]  = (i == 2) ? 32'd4 : 32'hA5A5_0000 + 32'(i);
         model_mem[i] = phys_mem[i];
      end
      exp_armed = 1'b0; exp_we = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rdata = '0;
      reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b0; MemRdComp = 1'b0; MemWrComp = 1'b0; mem_rdata = '0;
      #12;
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk1("rst_resp_err", resp_err, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_memrd", MemRd, 1'b0);
      chk1("rst_memwr", MemWr, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      do_access(1'b0, 32'h8, 32'h0, 3, 0, 1'b0, "ld8");
      chk("ld8_lit_strobes", o_strobes, 3);
      chk("ld8_lit_rdata", o_rdata, 32'd4);
      chk1("ld8_lit_err", o_err, 1'b0);

      do_access(1'b1, 32'h3C, 32'hDEADBEEF, 1, 0, 1'b0, "st3c");
      chk("st3c_lit_strobes", o_strobes, 1);
      chk1("st3c_lit_err", o_err, 1'b0);
      do_access(1'b0, 32'h3C, 32'h0, 2, 0, 1'b0, "ld3c");
      chk("ld3c_lit_rdata", o_rdata, 32'hDEADBEEF);

      do_access(1'b0, 32'h6, 32'h0, 1, 0, 1'b0, "ld_misalign");
      chk("misalign_lit_strobes", o_strobes, 0);
      chk1("misalign_lit_err", o_err, 1'b1);
      do_access(1'b0, 32'h40, 32'h0, 1, 0, 1'b0, "ld_range");
      chk1("range_lit_err", o_err, 1'b1);
      chk("range_lit_rdata", o_rdata, 32'h0);
      do_access(1'b1, 32'h3E, 32'h1111_2222, 1, 0, 1'b0, "st_misalign");

      do_access(1'b0, 32'h0, 32'h0, 0, 0, 1'b0, "ld_timeout");
      chk("timeout_lit_strobes", o_strobes, 15);
      chk1("timeout_lit_err", o_err, 1'b1);
      do_access(1'b1, 32'h24, 32'h5555_AAAA, 0, 0, 1'b0, "st_timeout");

      do_access(1'b0, 32'h4, 32'h0, 15, 0, 1'b0, "ld_tie");
      chk1("tie_lit_err", o_err, 1'b0);
      chk("tie_lit_rdata", o_rdata, 32'hA5A5_0001);

      do_access(1'b0, 32'h8, 32'h0, 4, 0, 1'b1, "ld_wrongcomp");
      chk("wrongcomp_lit_strobes", o_strobes, 4);

      do_access(1'b0, 32'hC, 32'h0, 2, 5, 1'b0, "ld_hold");
      do_access(1'b1, 32'h20, 32'h0BAD_F00D, 5, 0, 1'b0, "st20");
      do_access(1'b0, 32'h20, 32'h0, 1, 0, 1'b0, "ld20");

      exp_we = 1'b1; exp_addr = 32'h10; exp_wdata = 32'h1234_5678; exp_armed = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk1("rstmid_wr_active", MemWr, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk1("rstmid_memwr_drop", MemWr, 1'b0);
      chk1("rstmid_req_ready", req_ready, 1'b1);
      chk1("rstmid_no_resp", resp_valid, 1'b0);
      chk1("rstmid_stall", stall, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk1("rstmid_still_no_resp", resp_valid, 1'b0);
      chk1("rstmid_still_ready", req_ready, 1'b1);
      do_access(1'b0, 32'h10, 32'h0, 1, 0, 1'b0, "ld10_after_rst");
      chk("ld10_lit_rdata", o_rdata, 32'hA5A5_0004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
